// File: rtl/alu_bram32_control.sv
// alu_bram32_control: single-cycle RV32I-style control decoder, 32-bit ALU and
// a word-addressed data memory with one write port, a datapath read port and
// an always-on debug read port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instruction              32-bit instruction (opcode/func3/func7 decoded)
//   rs1, rs2, imm            register operands and sign-extended immediate
//   w_addr, w_dat, w_enb     external write port (used while init_done=0)
//   init_done                0: external port writes memory, 1: datapath does
//   debug_addr, debug_data   combinational debug read port
//   branch ... second_u_type_add_src   decoded control outputs (combinational)
//   alu_results, alu_zero    ALU result and zero flag
//   r_dat                    memory read data (0 unless mem_read)
module alu_bram32_control #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [9:0]  w_addr,
  input  logic [31:0] w_dat,
  input  logic        w_enb,
  input  logic        init_done,
  input  logic [9:0]  debug_addr,
  output logic [31:0] debug_data,
  output logic        branch,
  output logic [2:0]  imm_src,
  output logic        mem_read,
  output logic        mem_2_reg,
  output logic [3:0]  alu_ctrl,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  wrt_back_src,
  output logic        second_u_type_add_src,
  output logic [31:0] alu_results,
  output logic        alu_zero,
  output logic [31:0] r_dat
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_U   = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7_alt;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem [DEPTH];

  assign opcode    = instruction[6:0];
  assign func3     = instruction[14:12];
  assign func7_alt = instruction[30];

  // Input bits the block deliberately ignores (register indices, byte offsets).
  logic unused_bits;
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                         w_addr[1:0], debug_addr[1:0]};

  // Arithmetic op from func3; the alternate func7 bit picks SUB only for R-type.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    case (f3)
      3'b000:  arith_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Main decoder (everything except branch, which depends on the ALU flag).
  always_comb begin
    imm_src               = IMM_I;
    mem_read              = 1'b0;
    mem_2_reg             = 1'b0;
    alu_ctrl              = ALU_ADD;
    mem_write             = 1'b0;
    alu_src               = 1'b0;
    reg_write             = 1'b0;
    wrt_back_src          = WB_MEM;
    second_u_type_add_src = 1'b0;
    if (!rst) begin
      case (opcode)
        OPC_R: begin
          reg_write    = 1'b1;
          wrt_back_src = WB_ALU;
          alu_ctrl     = arith_op(func3, func7_alt, 1'b1);
        end
        OPC_I: begin
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          wrt_back_src = WB_ALU;
          alu_ctrl     = arith_op(func3, func7_alt, 1'b0);
        end
        OPC_LOAD: begin
          mem_read  = 1'b1;
          mem_2_reg = 1'b1;
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OPC_STORE: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_src   = IMM_S;
        end
        OPC_BRANCH: begin
          imm_src = IMM_B;
          case (func3[2:1])
            2'b10:   alu_ctrl = ALU_SLT;
            2'b11:   alu_ctrl = ALU_SLTU;
            default: alu_ctrl = ALU_SUB;
          endcase
        end
        OPC_JAL: begin
          imm_src      = IMM_J;
          reg_write    = 1'b1;
          wrt_back_src = WB_PC4;
        end
        OPC_JALR: begin
          alu_src      = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = WB_PC4;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_src               = IMM_U;
          reg_write             = 1'b1;
          wrt_back_src          = WB_U;
          second_u_type_add_src = (opcode == OPC_LUI);
        end
        default: ;
      endcase
    end
  end

  // Branch decision: equality/ordering tests map to the ALU zero flag.
  always_comb begin
    branch = 1'b0;
    if (!rst) begin
      case (opcode)
        OPC_JAL, OPC_JALR: branch = 1'b1;
        OPC_BRANCH: begin
          case (func3)
            3'b000, 3'b101, 3'b111: branch = alu_zero;
            3'b001, 3'b100, 3'b110: branch = !alu_zero;
            default:                branch = 1'b0;
          endcase
        end
        default: branch = 1'b0;
      endcase
    end
  end

  // ALU
  assign op_b  = alu_src ? imm : rs2;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_results = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_results = rs1 + op_b;
      ALU_SUB:  alu_results = rs1 - op_b;
      ALU_AND:  alu_results = rs1 & op_b;
      ALU_OR:   alu_results = rs1 | op_b;
      ALU_XOR:  alu_results = rs1 ^ op_b;
      ALU_SLL:  alu_results = rs1 << shamt;
      ALU_SRL:  alu_results = rs1 >> shamt;
      ALU_SRA:  alu_results = 32'($signed(rs1) >>> shamt);
      ALU_SLT:  alu_results = {31'b0, $signed(rs1) < $signed(op_b)};
      ALU_SLTU: alu_results = {31'b0, rs1 < op_b};
      default:  alu_results = '0;
    endcase
  end

  assign alu_zero = (alu_results == 32'h0);

  // Write-port source: external loader until init_done, then the datapath.
  assign mem_we    = init_done ? mem_write : w_enb;
  assign mem_waddr = init_done ? alu_results[AW+1:2] : w_addr[AW+1:2];
  assign mem_wdata = init_done ? rs2 : w_dat;

  // Memory contents survive reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign r_dat      = mem_read ? mem[alu_results[AW+1:2]] : 32'h0;
  assign debug_data = mem[debug_addr[AW+1:2]];

endmodule

// File: tb/tb_alu_bram32_control.sv
// Directed bench for alu_bram32_control: a mnemonic-level reference model is
// compared against every output on each falling edge, plus literal checks.
module tb_alu_bram32_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, rs1, rs2, imm, w_dat;
  logic [9:0]  w_addr, debug_addr;
  logic        w_enb, init_done;
  logic [31:0] debug_data, alu_results, r_dat;
  logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
  logic        second_u_type_add_src, alu_zero;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;

  always #5 clk = ~clk;

  alu_bram32_control #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rs1(rs1), .rs2(rs2),
    .imm(imm), .w_addr(w_addr), .w_dat(w_dat), .w_enb(w_enb),
    .init_done(init_done), .debug_addr(debug_addr), .debug_data(debug_data),
    .branch(branch), .imm_src(imm_src), .mem_read(mem_read),
    .mem_2_reg(mem_2_reg), .alu_ctrl(alu_ctrl), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .wrt_back_src(wrt_back_src),
    .second_u_type_add_src(second_u_type_add_src), .alu_results(alu_results),
    .alu_zero(alu_zero), .r_dat(r_dat)
  );

  typedef enum int {
    OP_NOP, OP_ILL, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
    OP_SRA, OP_OR, OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
    OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT,
    OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } op_e;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       mem_read;
    logic       mem_2_reg;
    logic [3:0] alu_ctrl;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] wb;
    logic       u2;
  } ctrl_t;

  int n_checks = 0;
  int n_fail   = 0;
  op_e cur_op;
  bit chk_en = 1'b0;

  logic [31:0] mmem [256];
  bit          mval [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction encoder: mnemonic -> {func7, rs2/rs1 fields, func3, rd, opcode}.
  function automatic logic [31:0] enc(input op_e op);
    logic [6:0] f7, opc;
    logic [2:0] f3;
    f7 = 7'h00; f3 = 3'b000; opc = 7'b0000000;
    case (op)
      OP_ILL:   opc = 7'b1110011;
      OP_ADD:   opc = 7'b0110011;
      OP_SUB:   begin opc = 7'b0110011; f7 = 7'h20; end
      OP_SLL:   begin opc = 7'b0110011; f3 = 3'b001; end
      OP_SLT:   begin opc = 7'b0110011; f3 = 3'b010; end
      OP_SLTU:  begin opc = 7'b0110011; f3 = 3'b011; end
      OP_XOR:   begin opc = 7'b0110011; f3 = 3'b100; end
      OP_SRL:   begin opc = 7'b0110011; f3 = 3'b101; end
      OP_SRA:   begin opc = 7'b0110011; f3 = 3'b101; f7 = 7'h20; end
      OP_OR:    begin opc = 7'b0110011; f3 = 3'b110; end
      OP_AND:   begin opc = 7'b0110011; f3 = 3'b111; end
      OP_ADDI:  opc = 7'b0010011;
      OP_SLTI:  begin opc = 7'b0010011; f3 = 3'b010; end
      OP_SLTIU: begin opc = 7'b0010011; f3 = 3'b011; end
      OP_XORI:  begin opc = 7'b0010011; f3 = 3'b100; end
      OP_ORI:   begin opc = 7'b0010011; f3 = 3'b110; end
      OP_ANDI:  begin opc = 7'b0010011; f3 = 3'b111; end
      OP_SLLI:  begin opc = 7'b0010011; f3 = 3'b001; end
      OP_SRLI:  begin opc = 7'b0010011; f3 = 3'b101; end
      OP_SRAI:  begin opc = 7'b0010011; f3 = 3'b101; f7 = 7'h20; end
      OP_LW:    begin opc = 7'b0000011; f3 = 3'b010; end
      OP_SW:    begin opc = 7'b0100011; f3 = 3'b010; end
      OP_BEQ:   opc = 7'b1100011;
      OP_BNE:   begin opc = 7'b1100011; f3 = 3'b001; end
      OP_BLT:   begin opc = 7'b1100011; f3 = 3'b100; end
      OP_BGE:   begin opc = 7'b1100011; f3 = 3'b101; end
      OP_BLTU:  begin opc = 7'b1100011; f3 = 3'b110; end
      OP_BGEU:  begin opc = 7'b1100011; f3 = 3'b111; end
      OP_JAL:   opc = 7'b1101111;
      OP_JALR:  opc = 7'b1100111;
      OP_LUI:   opc = 7'b0110111;
      OP_AUIPC: opc = 7'b0010111;
      default:  opc = 7'b0000000;
    endcase
    return {f7, 10'h2A5, f3, 5'h0B, opc};
  endfunction

  // Expected control bundle per instruction class.
  function automatic ctrl_t model_ctrl(input op_e op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd0; end
      OP_SUB:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd1; end
      OP_AND:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd2; end
      OP_OR:   begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd3; end
      OP_XOR:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd4; end
      OP_SLL:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd5; end
      OP_SRL:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd6; end
      OP_SRA:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd7; end
      OP_SLT:  begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd8; end
      OP_SLTU: begin c.reg_write = 1; c.wb = 2'b01; c.alu_ctrl = 4'd9; end
      OP_ADDI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd0; end
      OP_ANDI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd2; end
      OP_ORI:   begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd3; end
      OP_XORI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd4; end
      OP_SLLI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd5; end
      OP_SRLI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd6; end
      OP_SRAI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd7; end
      OP_SLTI:  begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd8; end
      OP_SLTIU: begin c.reg_write = 1; c.alu_src = 1; c.wb = 2'b01; c.alu_ctrl = 4'd9; end
      OP_LW: begin c.mem_read = 1; c.mem_2_reg = 1; c.reg_write = 1; c.alu_src = 1; end
      OP_SW: begin c.mem_write = 1; c.alu_src = 1; c.imm_src = 3'b001; end
      OP_BEQ, OP_BNE:   begin c.imm_src = 3'b010; c.alu_ctrl = 4'd1; end
      OP_BLT, OP_BGE:   begin c.imm_src = 3'b010; c.alu_ctrl = 4'd8; end
      OP_BLTU, OP_BGEU: begin c.imm_src = 3'b010; c.alu_ctrl = 4'd9; end
      OP_JAL:   begin c.imm_src = 3'b011; c.reg_write = 1; c.wb = 2'b10; end
      OP_JALR:  begin c.alu_src = 1; c.reg_write = 1; c.wb = 2'b10; end
      OP_LUI:   begin c.imm_src = 3'b100; c.reg_write = 1; c.wb = 2'b11; c.u2 = 1; end
      OP_AUIPC: begin c.imm_src = 3'b100; c.reg_write = 1; c.wb = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  // Expected ALU result from the instruction's arithmetic meaning.
  function automatic logic [31:0] model_res(input op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] i);
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_JALR: return a + i;
      OP_SUB, OP_BEQ, OP_BNE:         return a - b;
      OP_AND:   return a & b;
      OP_ANDI:  return a & i;
      OP_OR:    return a | b;
      OP_ORI:   return a | i;
      OP_XOR:   return a ^ b;
      OP_XORI:  return a ^ i;
      OP_SLL:   return a << b[4:0];
      OP_SLLI:  return a << i[4:0];
      OP_SRL:   return a >> b[4:0];
      OP_SRLI:  return a >> i[4:0];
      OP_SRA:   return 32'($signed(a) >>> b[4:0]);
      OP_SRAI:  return 32'($signed(a) >>> i[4:0]);
      OP_SLT, OP_BLT, OP_BGE:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTI:                   return ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
      OP_SLTU, OP_BLTU, OP_BGEU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLTIU:                  return (a < i) ? 32'd1 : 32'd0;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic model_branch(input op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_JAL, OP_JALR: return 1'b1;
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return $signed(a) < $signed(b);
      OP_BGE:  return $signed(a) >= $signed(b);
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  op_e         eff;
  ctrl_t       ec, ac;
  logic [31:0] er;
  logic [7:0]  ix;

  // Compare process: checks all outputs each falling edge, then commits the
  // write the next rising edge will perform into the model memory.
  always @(negedge clk) begin
    if (chk_en) begin
      eff = rst ? OP_NOP : cur_op;
      ec  = model_ctrl(eff);
      er  = model_res(eff, rs1, rs2, imm);
      ac  = {imm_src, mem_read, mem_2_reg, alu_ctrl, mem_write, alu_src,
             reg_write, wrt_back_src, second_u_type_add_src};
      chk("ctrl_bundle", 32'(ac), 32'(ec));
      chk("branch", 32'(branch), 32'(model_branch(eff, rs1, rs2)));
      chk("alu_results", alu_results, er);
      chk("alu_zero", 32'(alu_zero), 32'(er == 32'h0));
      ix = er[9:2];
      if (!ec.mem_read)  chk("r_dat_idle", r_dat, 32'h0);
      else if (mval[ix]) chk("r_dat", r_dat, mmem[ix]);
      ix = debug_addr[9:2];
      if (mval[ix]) chk("debug_data", debug_data, mmem[ix]);
      if (!rst) begin
        if (init_done && eff == OP_SW) begin
          ix = er[9:2]; mmem[ix] = rs2; mval[ix] = 1'b1;
        end else if (!init_done && w_enb) begin
          ix = w_addr[9:2]; mmem[ix] = w_dat; mval[ix] = 1'b1;
        end
      end
    end
  end

  // New instruction/operands shortly after each rising edge.
  task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i);
    @(posedge clk);
    #1;
    cur_op = op; instruction = enc(op); rs1 = a; rs2 = b; imm = i;
  endtask

  op_e sweep_ops [25] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                          OP_SRA, OP_OR, OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_SLLI,
                          OP_SRLI, OP_SRAI, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUIPC, OP_ILL, OP_NOP};

  initial begin
    rst = 1'b1; init_done = 1'b0; w_enb = 1'b0; w_addr = '0; w_dat = '0;
    debug_addr = '0; cur_op = OP_NOP; instruction = enc(OP_NOP);
    rs1 = '0; rs2 = '0; imm = '0;
    chk_en = 1'b1;

    // Reset forces controls low even with a STORE presented.
    drive(OP_SW, 32'h0, 32'h1, 32'h8); #1;
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_alu_src", 32'(alu_src), 32'h0);
    chk("rst_imm_src", 32'(imm_src), 32'h0);

    // Release reset between edges; decoder responds at once.
    drive(OP_XORI, 32'hF, 32'h0, 32'h5); rst = 1'b0; #1;
    chk("release_reg_write", 32'(reg_write), 32'h1);

    // External loader writes.
    drive(OP_NOP, 0, 0, 0); w_enb = 1'b1; w_addr = 10'd0; w_dat = 32'h0000000F;
    drive(OP_NOP, 0, 0, 0); w_addr = 10'd4; w_dat = 32'h00000005; #1;
    chk("load_word0", debug_data, 32'h0000000F);
    drive(OP_NOP, 0, 0, 0); w_enb = 1'b0; debug_addr = 10'd4; init_done = 1'b1; #1;
    chk("load_word1", debug_data, 32'h00000005);

    drive(OP_XORI, 32'hF, 32'h0, 32'h5); #1;
    chk("xori_alu_ctrl", 32'(alu_ctrl), 32'h4);
    chk("xori_alu_src", 32'(alu_src), 32'h1);
    chk("xori_wb", 32'(wrt_back_src), 32'h1);
    chk("xori_result", alu_results, 32'h0000000A);
    chk("xori_zero", 32'(alu_zero), 32'h0);
    drive(OP_ANDI, 32'hF, 32'h0, 32'h5); #1;
    chk("andi_result", alu_results, 32'h00000005);
    drive(OP_ORI, 32'h38, 32'h0, 32'h2); #1;
    chk("ori_result", alu_results, 32'h0000003A);
    drive(OP_ANDI, 32'hF, 32'h0, 32'h0); #1;
    chk("andi_zero", 32'(alu_zero), 32'h1);

    drive(OP_LW, 32'h0, 32'h0, 32'h4); #1;
    chk("lw_mem_read", 32'(mem_read), 32'h1);
    chk("lw_wb", 32'(wrt_back_src), 32'h0);
    chk("lw_r_dat", r_dat, 32'h00000005);
    drive(OP_SW, 32'h0, 32'hDEADBEEF, 32'h8); debug_addr = 10'd8;
    drive(OP_NOP, 0, 0, 0); #1;
    chk("sw_readback", debug_data, 32'hDEADBEEF);

    drive(OP_BEQ, 32'd7, 32'd7, 32'h0); #1;
    chk("beq_taken", 32'(branch), 32'h1);
    drive(OP_BNE, 32'd7, 32'd7, 32'h0); #1;
    chk("bne_not_taken", 32'(branch), 32'h0);
    drive(OP_BLT, 32'hFFFFFFFF, 32'd1, 32'h0); #1;
    chk("blt_signed", 32'(branch), 32'h1);

    // Address wraps modulo 1 KiB and ignores byte offset bits.
    drive(OP_LW, 32'h00000400, 32'h0, 32'h7); #1;
    chk("lw_wrap", r_dat, 32'h00000005);

    // ALU boundary values.
    drive(OP_SRA, 32'h80000010, 32'h00000023, 32'h0); #1;
    chk("sra_b40", alu_results, 32'hF0000002);
    drive(OP_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0); #1;
    chk("sub_wrap", alu_results, 32'h80000000);
    drive(OP_SLT, 32'd1, 32'hFFFFFFFF, 32'h0); #1;
    chk("slt_signed", alu_results, 32'h0);
    drive(OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'h0); #1;
    chk("sltu_unsigned", alu_results, 32'h1);

    // Sweep remaining instruction classes; the compare process checks them.
    foreach (sweep_ops[k]) begin
      drive(sweep_ops[k], 32'h80000010, 32'h00000003, 32'hFFFFFFF4);
      drive(sweep_ops[k], 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000021);
    end

    // Reading the word being written this cycle returns the old value.
    drive(OP_LW, 32'h8, 32'h0, 32'h0);
    init_done = 1'b0; w_enb = 1'b1; w_addr = 10'd8; w_dat = 32'h11111111; #1;
    chk("read_during_write", r_dat, 32'hDEADBEEF);
    drive(OP_NOP, 0, 0, 0); w_enb = 1'b0; init_done = 1'b1; #1;
    chk("write_landed", debug_data, 32'h11111111);

    // Reset during a STORE: no write, contents kept.
    drive(OP_SW, 32'h0, 32'h12345678, 32'h8); rst = 1'b1; #1;
    chk("rst_store_we", 32'(mem_write), 32'h0);
    chk("rst_store_rw", 32'(reg_write), 32'h0);
    chk("rst_r_dat", r_dat, 32'h0);
    drive(OP_NOP, 0, 0, 0); rst = 1'b0; #1;
    chk("rst_preserve", debug_data, 32'h11111111);

    drive(OP_NOP, 0, 0, 0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
